// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo_prog family: default parameters,
// width helpers and the pointer type used for wrap arithmetic.
package sync_fifo_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AF_LEVEL = 14;
  localparam int DEF_AE_LEVEL = 2;

  // Widest pointer the helper arithmetic handles (DEPTH up to 65536).
  localparam int PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  // Bits needed to hold a fill level from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries (depth >= 2).
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Increment with explicit wrap at the last entry, so non-power-of-two
  // depths never step into unused addresses.
  function automatic ptr_t ptr_inc_wrap(input ptr_t p, input ptr_t last);
    return (p == last) ? '0 : ptr_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer side of sync_fifo_prog. overflow/underflow exist only
// when SYNC_FIFO_ERR_EN is defined.
interface sync_fifo_prog_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = sync_fifo_pkg::cnt_w(DEPTH);

  logic             winc;
  logic [WIDTH-1:0] wdata;
  logic             rinc;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             wfull;
  logic             rempty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
`ifdef SYNC_FIFO_ERR_EN
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output winc, wdata, rinc,
    input  rdata, rvalid, wfull, rempty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, rvalid, wfull, rempty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_EN
    , output overflow, underflow
`endif
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM, DEPTH x WIDTH, single clock, registered read port.
// Only the read register is reset; storage contents are left as-is.
module sync_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: store the accepted word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port: register the addressed word on a read, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, exact fill count and programmable
// almost-full / almost-empty thresholds. Optional sticky overflow/underflow
// flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_prog_if.slave fifo
);

  localparam int   CW   = cnt_w(DEPTH);
  localparam int   AW   = addr_w(DEPTH);
  localparam ptr_t LAST = ptr_t'(DEPTH - 1);

  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rvalid_q;
  logic          wfull, rempty, wen, ren;

  // Accept decode and next-state for pointers and fill level.
  always_comb begin
    wfull   = (count_q == CW'(DEPTH));
    rempty  = (count_q == '0);
    wen     = fifo.winc & ~wfull;
    ren     = fifo.rinc & ~rempty;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    count_d = count_q;
    if (wen) waddr_d = AW'(ptr_inc_wrap(ptr_t'(waddr_q), LAST));
    if (ren) raddr_d = AW'(ptr_inc_wrap(ptr_t'(raddr_q), LAST));
    if (wen && !ren)      count_d = count_q + 1'b1;
    else if (ren && !wen) count_d = count_q - 1'b1;
  end

  // Control state register; requests in the reset cycle are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q  <= '0;
      raddr_q  <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      count_q  <= count_d;
      rvalid_q <= ren;
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wen & ~rst),
    .waddr_i (waddr_q),
    .wdata_i (fifo.wdata),
    .re_i    (ren & ~rst),
    .raddr_i (raddr_q),
    .rdata_o (fifo.rdata)
  );

  assign fifo.rvalid       = rvalid_q;
  assign fifo.count        = count_q;
  assign fifo.wfull        = wfull;
  assign fifo.rempty       = rempty;
  assign fifo.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign fifo.almost_empty = (count_q <= CW'(AE_LEVEL));

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // Sticky error accumulation from rejected requests.
  always_comb begin
    ovf_d = ovf_q | (fifo.winc & wfull);
    udf_d = udf_q | (fifo.rinc & rempty);
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign fifo.overflow  = ovf_q;
  assign fifo.underflow = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: a DEPTH=16 instance for the main
// scenarios and a DEPTH=5 instance for non-power-of-two wrap laps.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_prog_if #(.WIDTH(8), .DEPTH(16)) f16 ();
  sync_fifo_prog_if #(.WIDTH(8), .DEPTH(5))  f5  ();

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) u_dut16 (
    .clk  (clk),
    .rst  (rst),
    .fifo (f16)
  );

  sync_fifo_prog #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
    .clk  (clk),
    .rst  (rst),
    .fifo (f5)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q16[$];
  logic [7:0] q5[$];
  logic [7:0] last16 = '0;
  logic [7:0] last5  = '0;
`ifdef SYNC_FIFO_ERR_EN
  bit of16 = 1'b0;
  bit uf16 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock on the DEPTH=16 instance with a reference-queue model.
  task automatic cyc(input bit w, input logic [7:0] d, input bit r);
    int sz;
    bit wen_m, ren_m;
    sz    = q16.size();
    wen_m = w && (sz < 16);
    ren_m = r && (sz > 0);
`ifdef SYNC_FIFO_ERR_EN
    of16 = of16 | (w && sz == 16);
    uf16 = uf16 | (r && sz == 0);
`endif
    f16.winc  = w;
    f16.wdata = d;
    f16.rinc  = r;
    @(posedge clk);
    #1;
    f16.winc = 1'b0;
    f16.rinc = 1'b0;
    if (ren_m) last16 = q16.pop_front();
    if (wen_m) q16.push_back(d);
    check("rvalid16", f16.rvalid, ren_m);
    check("rdata16", f16.rdata, last16);
    check("count16", f16.count, q16.size());
    check("wfull16", f16.wfull, q16.size() == 16);
    check("rempty16", f16.rempty, q16.size() == 0);
    check("afull16", f16.almost_full, q16.size() >= 14);
    check("aempty16", f16.almost_empty, q16.size() <= 2);
`ifdef SYNC_FIFO_ERR_EN
    check("overflow16", f16.overflow, of16);
    check("underflow16", f16.underflow, uf16);
`endif
  endtask

  // One clock on the DEPTH=5 instance.
  task automatic cyc5(input bit w, input logic [7:0] d, input bit r);
    int sz;
    bit wen_m, ren_m;
    sz    = q5.size();
    wen_m = w && (sz < 5);
    ren_m = r && (sz > 0);
    f5.winc  = w;
    f5.wdata = d;
    f5.rinc  = r;
    @(posedge clk);
    #1;
    f5.winc = 1'b0;
    f5.rinc = 1'b0;
    if (ren_m) last5 = q5.pop_front();
    if (wen_m) q5.push_back(d);
    check("rvalid5", f5.rvalid, ren_m);
    check("rdata5", f5.rdata, last5);
    check("count5", f5.count, q5.size());
    check("wfull5", f5.wfull, q5.size() == 5);
  endtask

  // One reset cycle, optionally with a write request that must be lost.
  task automatic do_rst(input bit w);
    f16.winc  = w;
    f16.wdata = 8'hCC;
    f16.rinc  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    f16.winc = 1'b0;
    q16.delete();
    q5.delete();
    last16 = '0;
    last5  = '0;
`ifdef SYNC_FIFO_ERR_EN
    of16 = 1'b0;
    uf16 = 1'b0;
    check("rst_overflow", f16.overflow, 1'b0);
    check("rst_underflow", f16.underflow, 1'b0);
`endif
    check("rst_count", f16.count, 0);
    check("rst_rempty", f16.rempty, 1'b1);
    check("rst_wfull", f16.wfull, 1'b0);
    check("rst_aempty", f16.almost_empty, 1'b1);
    check("rst_afull", f16.almost_full, 1'b0);
    check("rst_rvalid", f16.rvalid, 1'b0);
    check("rst_rdata", f16.rdata, 8'h00);
    check("rst_count5", f5.count, 0);
  endtask

  initial begin
    f16.winc = 1'b0; f16.wdata = '0; f16.rinc = 1'b0;
    f5.winc  = 1'b0; f5.wdata  = '0; f5.rinc  = 1'b0;
    @(posedge clk);
    do_rst(1'b0);

    // Read while empty: rejected (sets underflow when enabled).
    cyc(1'b0, 8'h00, 1'b1);

    // Fill 0x00..0x0F, then one extra write while full.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'hAA, 1'b0);

    // Drain all 16 in order.
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    check("drain_last", last16, 8'h0F);

    // Refill and hit full with simultaneous requests: only the read goes.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    cyc(1'b1, 8'hEE, 1'b1);
    check("full_both_count", f16.count, 15);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
    check("full_both_last", last16, 8'h1F);

    // Empty with simultaneous requests: only the write goes.
    cyc(1'b1, 8'h55, 1'b1);
    check("empty_both_rvalid", f16.rvalid, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check("empty_both_word", f16.rdata, 8'h55);

    // Steady streaming at count 8.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 50; i++) cyc(1'b1, 8'($urandom), 1'b1);
    check("stream_count", f16.count, 8);

    // Reset mid-operation at count 10 with a write in flight.
    cyc(1'b1, 8'h91, 1'b0);
    cyc(1'b1, 8'h92, 1'b0);
    do_rst(1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h3C, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check("post_rst_word", f16.rdata, 8'h3C);

    // Non-power-of-two wrap: three fill/drain laps on DEPTH=5.
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 6; i++) cyc5(1'b1, 8'(lap * 8 + i), 1'b0);
      for (int i = 0; i < 5; i++) cyc5(1'b0, 8'h00, 1'b1);
      check("lap_last5", last5, 8'(lap * 8 + 4));
    end
    cyc5(1'b1, 8'h77, 1'b1);
    cyc5(1'b1, 8'h78, 1'b1);
    check("wrap_stream5", f5.rdata, 8'h77);

    // Normal traffic after errors, then reset clears everything.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hB0 + i), i[0]);
    do_rst(1'b0);
    cyc(1'b1, 8'h01, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
